cache_bus_axi_bridge: RTL and testbench
=======================================

Name: cache_bus_axi_bridge

Overview:
- Downstream of the uncached LSU and the I/D cache refill/writeback paths; consumes the cache bus request/response protocol and produces one AXI4 master port.
- Handles one transaction at a time: single-beat uncached accesses and BURST_LEN-beat cached line bursts.
- Write completion is reported to the cache bus only after the AXI B response returns.

Parameters:
- BURST_LEN, 4: beats per cached burst; AXI len = BURST_LEN-1.
- AXI_ID, 4'd0: constant ID driven on awid and arid.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  address-phase request valid
- req_write_i  in  1  1 = write, 0 = read
- req_burst_i  in  1  1 = BURST_LEN beats, 0 = single beat
- req_cached_i  in  1  cacheable attribute
- req_addr_i  in  32  byte address
- req_w_data_i  in  32  write beat data
- req_data_strobe_i  in  4  write byte enables
- req_data_ok_i  in  1  master data-phase valid (write) / ready (read)
- req_data_last_i  in  1  master marks final write beat
- resp_ready_o  out  1  address phase accepted
- resp_r_data_o  out  32  read beat data
- resp_data_ok_o  out  1  bridge data-phase ready (write) / valid (read)
- resp_data_last_o  out  1  final read beat
- AXI AR channel: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arcache 4, arvalid out 1, arready in 1
- AXI R channel: rid 4, rdata 32, rresp 2, rlast 1, rvalid in 1, rready out 1
- AXI AW channel: same field set as AR; awvalid out 1, awready in 1
- AXI W channel: wdata 32, wstrb 4, wlast 1, wvalid out 1, wready in 1
- AXI B channel: bid 4, bresp 2, bvalid in 1, bready out 1
- err_cnt_o  out  16  AXI error-response count (optional feature)

Behaviour:
- Reset: FSM returns to IDLE. resp_ready_o=1; all other outputs 0, including every AXI valid/ready, resp_data_ok_o and err_cnt_o. A reset during any transaction abandons it with no drain.
- FSM states: IDLE, AR, R, AW, W, B, WACK.
- IDLE
  - resp_ready_o=1.
  - On req_valid_i, latch addr, write, burst and cached.
  - Next state is AW if write, otherwise AR.
  - resp_ready_o=0 in every other state.
- Address fields
  - ax addr = latched addr.
  - len = burst ? BURST_LEN-1 : 0.
  - size = 3'b010.
  - burst type = INCR (2'b01).
  - cache = cached ? 4'b1111 : 4'b0000.
  - id = AXI_ID.
- AR
  - arvalid=1, held stable until arready.
  - On arready, go to R.
- R
  - resp_data_ok_o = rvalid.
  - resp_r_data_o = rdata.
  - resp_data_last_o = rlast.
  - rready = req_data_ok_i.
  - On rvalid & rready & rlast, go to IDLE (same cycle the beat is delivered).
- AW
  - awvalid=1 until awready, then go to W.
  - W channel is never driven before AW completes.
- W
  - wvalid = req_data_ok_i, wdata = req_w_data_i, wstrb = req_data_strobe_i, wlast = req_data_last_i.
  - Non-last beat: resp_data_ok_o = wready.
  - Last beat: resp_data_ok_o=0 and the master keeps holding the beat. On wvalid & wready & wlast, go to B.
- B
  - bready=1, wvalid=0.
  - On bvalid, go to WACK.
- WACK
  - resp_data_ok_o=1 for exactly one cycle, acknowledging the held last beat.
  - Go to IDLE.
- Latencies
  - Minimum single read: req accept to data_ok is 2 cycles plus AXI latency.
  - Write last-beat acknowledge comes 1 cycle after B.
- Beat mismatch: if the master's data_last disagrees with the beat count, the bridge follows req_data_last_i and does not check.
- resp_r_data_o is 0 outside R.
- bresp/rresp errors do not alter the flow; data is passed through as-is.

Optional Feature:
- Macro: CACHE_BUS_AXI_ERR_CNT_EN.
- Enabled
  - 16-bit counter increments on each R handshake with rresp≠OKAY and each B handshake with bresp≠OKAY.
  - Saturates at 16'hFFFF; cleared only by reset.
  - Drives err_cnt_o.
- Disabled: err_cnt_o tied to 0 and no counter logic.

Test Plan:
- Uncached word read at 0x1FD0_0010: arlen=0, arsize=2, arcache=0. rdata=0xDEADBEEF with rlast -> resp_data_ok_o & resp_data_last_o=1 with data 0xDEADBEEF, then FSM in IDLE and resp_ready_o=1.
- Cached burst read at 0x0000_1000, BURST_LEN=4: arlen=3, arcache=4'hF. Master holds req_data_ok_i low 2 cycles mid-burst -> rready=0 on those cycles; all 4 beats delivered in order, last flagged.
- Uncached byte write at addr 0x...03, strobe 4'b1000: AW before W. resp_data_ok_o stays 0 through the W handshake and is asserted exactly one cycle after bvalid; no second W beat issued.
- Cached 4-beat writeback with wready stalls: first 3 beats acked on wready, 4th acked only in WACK; wlast=1 on beat 4 only.
- Reset asserted in R after 2 of 4 beats: next cycle arvalid/rready/resp_data_ok_o=0, resp_ready_o=1; a new read then completes normally.
- With CACHE_BUS_AXI_ERR_CNT_EN: one read with rresp=SLVERR and one write with bresp=DECERR -> err_cnt_o=2. Without the macro: err_cnt_o=0.

Source files
------------

// File: rtl/cache_bus_axi_bridge.sv
// Cache bus to AXI4 master bridge: one outstanding transaction, single-beat or BURST_LEN-beat INCR bursts.
// Optional AXI error-response counter enabled by defining CACHE_BUS_AXI_ERR_CNT_EN.
module cache_bus_axi_bridge #(
    parameter int         BURST_LEN = 4,
    parameter logic [3:0] AXI_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic        req_burst_i,
    input  logic        req_cached_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_w_data_i,
    input  logic [3:0]  req_data_strobe_i,
    input  logic        req_data_ok_i,
    input  logic        req_data_last_i,
    output logic        resp_ready_o,
    output logic [31:0] resp_r_data_o,
    output logic        resp_data_ok_o,
    output logic        resp_data_last_o,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arcache,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [3:0]  awcache,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [15:0] err_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_WACK
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic        r_write;
    logic        r_burst;
    logic        r_cached;
    logic [7:0]  w_len;
    logic [3:0]  w_cache;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Request attributes are data-path state; only the FSM needs reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && req_valid_i) begin
            r_addr   <= req_addr_i;
            r_write  <= req_write_i;
            r_burst  <= req_burst_i;
            r_cached <= req_cached_i;
        end
    end

    assign w_len   = r_burst ? 8'(BURST_LEN - 1) : 8'd0;
    assign w_cache = r_cached ? 4'b1111 : 4'b0000;

    always_comb begin
        w_next           = r_state;
        resp_ready_o     = 1'b0;
        resp_r_data_o    = 32'd0;
        resp_data_ok_o   = 1'b0;
        resp_data_last_o = 1'b0;
        arid             = 4'd0;
        araddr           = 32'd0;
        arlen            = 8'd0;
        arsize           = 3'd0;
        arburst          = 2'd0;
        arcache          = 4'd0;
        arvalid          = 1'b0;
        rready           = 1'b0;
        awid             = 4'd0;
        awaddr           = 32'd0;
        awlen            = 8'd0;
        awsize           = 3'd0;
        awburst          = 2'd0;
        awcache          = 4'd0;
        awvalid          = 1'b0;
        wdata            = 32'd0;
        wstrb            = 4'd0;
        wlast            = 1'b0;
        wvalid           = 1'b0;
        bready           = 1'b0;
        case (r_state)
            S_IDLE: begin
                resp_ready_o = 1'b1;
                if (req_valid_i) w_next = req_write_i ? S_AW : S_AR;
            end
            S_AR: begin
                arid    = AXI_ID;
                araddr  = r_addr;
                arlen   = w_len;
                arsize  = 3'b010;
                arburst = 2'b01;
                arcache = w_cache;
                arvalid = 1'b1;
                if (arready) w_next = S_R;
            end
            S_R: begin
                resp_data_ok_o   = rvalid;
                resp_r_data_o    = rdata;
                resp_data_last_o = rlast;
                rready           = req_data_ok_i;
                if (rvalid && req_data_ok_i && rlast) w_next = S_IDLE;
            end
            S_AW: begin
                awid    = AXI_ID;
                awaddr  = r_addr;
                awlen   = w_len;
                awsize  = 3'b010;
                awburst = 2'b01;
                awcache = w_cache;
                awvalid = 1'b1;
                if (awready) w_next = S_W;
            end
            S_W: begin
                wvalid = req_data_ok_i;
                wdata  = req_w_data_i;
                wstrb  = req_data_strobe_i;
                wlast  = req_data_last_i;
                // The last beat is acknowledged only once the B response is back.
                resp_data_ok_o = wready && !req_data_last_i;
                if (req_data_ok_i && wready && req_data_last_i) w_next = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) w_next = S_WACK;
            end
            S_WACK: begin
                resp_data_ok_o = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef CACHE_BUS_AXI_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic        w_err_evt;

    assign w_err_evt = (r_state == S_R && rvalid && req_data_ok_i && rresp != 2'b00) ||
                       (r_state == S_B && bvalid && bresp != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n)                                r_err_cnt <= 16'd0;
        else if (w_err_evt && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_cnt_o = r_err_cnt;

    logic w_unused;
    assign w_unused = ^{rid, bid, r_write};
`else
    assign err_cnt_o = 16'd0;

    logic w_unused;
    assign w_unused = ^{rid, bid, rresp, bresp, r_write};
`endif

endmodule

// File: tb/tb_cache_bus_axi_bridge.sv
// Randomized bench for cache_bus_axi_bridge: the bench plays both the cache-bus master and the AXI slave.
module tb_cache_bus_axi_bridge;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_write_i, req_burst_i, req_cached_i;
    logic [31:0] req_addr_i, req_w_data_i;
    logic [3:0]  req_data_strobe_i;
    logic        req_data_ok_i, req_data_last_i;
    logic        resp_ready_o, resp_data_ok_o, resp_data_last_o;
    logic [31:0] resp_r_data_o;
    logic [3:0]  arid, awid, rid, bid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [15:0] err_cnt_o;

    cache_bus_axi_bridge #(.BURST_LEN(BL), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_burst_i(req_burst_i),
        .req_cached_i(req_cached_i), .req_addr_i(req_addr_i), .req_w_data_i(req_w_data_i),
        .req_data_strobe_i(req_data_strobe_i), .req_data_ok_i(req_data_ok_i),
        .req_data_last_i(req_data_last_i), .resp_ready_o(resp_ready_o),
        .resp_r_data_o(resp_r_data_o), .resp_data_ok_o(resp_data_ok_o),
        .resp_data_last_o(resp_data_last_o),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arcache(arcache), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awcache(awcache), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] slave_mem [64];
    logic [31:0] ref_mem   [64];
    int          exp_err = 0;
    int          g_rresp = -1;
    int          g_bresp = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [1:0] pick_resp(input int mode);
        if (mode >= 0) return 2'(mode);
        return ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
    endfunction

    task automatic bump_err(input logic [1:0] r);
        if (r != 2'b00 && exp_err < 65535) exp_err++;
    endtask

    task automatic chk_err_cnt();
`ifdef CACHE_BUS_AXI_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt_o), 32'(exp_err));
`else
        chk("err_cnt", 32'(err_cnt_o), 32'd0);
`endif
    endtask

    task automatic idle_slave();
        arready = 0; awready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
        wready = 0; bvalid = 0; bresp = 0; rid = 0; bid = 0;
    endtask

    // Present a request in IDLE, then run the address phase with random ready stalls.
    task automatic start_req(input logic wr, input logic [31:0] addr, input logic burst,
                             input logic cached, input logic [31:0] d0, input logic [3:0] s0,
                             output logic [31:0] got_addr);
        int k = $urandom_range(0, 2);
        @(negedge clk);
        idle_slave();
        req_valid_i = 1; req_write_i = wr; req_burst_i = burst; req_cached_i = cached;
        req_addr_i = addr; req_data_ok_i = 0; req_data_last_i = 0;
        #1 chk("idle_ready", 32'(resp_ready_o), 32'd1);
        got_addr = 0;
        for (int c = 0; c <= k; c++) begin
            @(negedge clk);
            idle_slave();
            req_valid_i = 0;
            req_data_ok_i = wr;
            req_w_data_i = d0; req_data_strobe_i = s0; req_data_last_i = wr && !burst;
            if (wr) awready = (c == k); else arready = (c == k);
            #1;
            chk("busy_ready", 32'(resp_ready_o), 32'd0);
            chk("addr_ok", 32'(resp_data_ok_o), 32'd0);
            if (wr) begin
                chk("awvalid", 32'(awvalid), 32'd1);
                chk("awaddr", awaddr, addr);
                chk("awlen", 32'(awlen), burst ? 32'(BL - 1) : 32'd0);
                chk("awsize", 32'(awsize), 32'd2);
                chk("awburst", 32'(awburst), 32'd1);
                chk("awcache", 32'(awcache), cached ? 32'hF : 32'h0);
                chk("awid", 32'(awid), 32'd0);
                chk("w_early", 32'(wvalid), 32'd0);
                chk("ar_in_wr", 32'(arvalid), 32'd0);
                got_addr = awaddr;
            end else begin
                chk("arvalid", 32'(arvalid), 32'd1);
                chk("araddr", araddr, addr);
                chk("arlen", 32'(arlen), burst ? 32'(BL - 1) : 32'd0);
                chk("arsize", 32'(arsize), 32'd2);
                chk("arburst", 32'(arburst), 32'd1);
                chk("arcache", 32'(arcache), cached ? 32'hF : 32'h0);
                chk("arid", 32'(arid), 32'd0);
                chk("aw_in_rd", 32'(awvalid), 32'd0);
                got_addr = araddr;
            end
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic burst, input logic cached,
                           input int abort_after);
        logic [31:0] ga;
        int n = burst ? BL : 1;
        start_req(1'b0, addr, burst, cached, 32'd0, 4'd0, ga);
        for (int i = 0; i < n; i++) begin
            int k = $urandom_range(0, 3);
            if (i == abort_after) begin
                @(negedge clk);
                idle_slave();
                rst_n = 0; rvalid = 1; rdata = $urandom; req_data_ok_i = 1;
                @(negedge clk);
                #1;
                chk("rst_arvalid", 32'(arvalid), 32'd0);
                chk("rst_rready", 32'(rready), 32'd0);
                chk("rst_data_ok", 32'(resp_data_ok_o), 32'd0);
                chk("rst_rdata", resp_r_data_o, 32'd0);
                chk("rst_ready", 32'(resp_ready_o), 32'd1);
                exp_err = 0;
                chk_err_cnt();
                rst_n = 1; req_data_ok_i = 0; rvalid = 0;
                return;
            end
            for (int c = 0; c <= k; c++) begin
                logic hs = (c == k);
                logic rv, dok;
                logic [1:0] rr;
                rv  = hs ? 1'b1 : 1'($urandom_range(0, 1));
                dok = hs ? 1'b1 : (rv ? 1'b0 : 1'($urandom_range(0, 1)));
                rr  = hs ? pick_resp(g_rresp) : 2'b00;
                @(negedge clk);
                idle_slave();
                rvalid = rv; rlast = (i == n - 1); rresp = rr;
                rdata = rv ? slave_mem[idx(ga + 32'(4 * i))] : $urandom;
                req_data_ok_i = dok;
                #1;
                chk("rready", 32'(rready), 32'(dok));
                chk("r_data_ok", 32'(resp_data_ok_o), 32'(rv));
                if (rv) begin
                    chk("r_data", resp_r_data_o, ref_mem[idx(addr + 32'(4 * i))]);
                    chk("r_last", 32'(resp_data_last_o), 32'(i == n - 1));
                end
                if (hs) bump_err(rr);
            end
        end
        @(negedge clk);
        idle_slave();
        req_data_ok_i = 0;
        #1;
        chk("r_done_ready", 32'(resp_ready_o), 32'd1);
        chk("r_done_ok", 32'(resp_data_ok_o), 32'd0);
        chk("r_done_rdata", resp_r_data_o, 32'd0);
        chk_err_cnt();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic burst, input logic cached,
                            input logic [31:0] d [4], input logic [3:0] s [4]);
        logic [31:0] ga;
        int n = burst ? BL : 1;
        int kb;
        start_req(1'b1, addr, burst, cached, d[0], s[0], ga);
        for (int i = 0; i < n; i++) begin
            int k = $urandom_range(0, 3);
            logic last = (i == n - 1);
            for (int c = 0; c <= k; c++) begin
                logic hs = (c == k);
                logic dok, wr;
                dok = hs ? 1'b1 : 1'($urandom_range(0, 1));
                wr  = hs ? 1'b1 : (dok ? 1'b0 : 1'($urandom_range(0, 1)));
                @(negedge clk);
                idle_slave();
                wready = wr;
                req_data_ok_i = dok; req_w_data_i = d[i]; req_data_strobe_i = s[i];
                req_data_last_i = last;
                #1;
                chk("wvalid", 32'(wvalid), 32'(dok));
                chk("wdata", wdata, d[i]);
                chk("wstrb", 32'(wstrb), 32'(s[i]));
                chk("wlast", 32'(wlast), 32'(last));
                chk("w_data_ok", 32'(resp_data_ok_o), last ? 32'd0 : 32'(wr));
                chk("w_awvalid", 32'(awvalid), 32'd0);
                if (hs) begin
                    slave_mem[idx(ga + 32'(4 * i))] = merge(slave_mem[idx(ga + 32'(4 * i))], wdata, wstrb);
                    ref_mem[idx(addr + 32'(4 * i))] = merge(ref_mem[idx(addr + 32'(4 * i))], d[i], s[i]);
                end
            end
        end
        kb = $urandom_range(0, 2);
        for (int c = 0; c <= kb; c++) begin
            logic [1:0] br = (c == kb) ? pick_resp(g_bresp) : 2'b00;
            @(negedge clk);
            idle_slave();
            wready = 1'($urandom_range(0, 1));
            bvalid = (c == kb); bresp = br;
            #1;
            chk("bready", 32'(bready), 32'd1);
            chk("b_wvalid", 32'(wvalid), 32'd0);
            chk("b_data_ok", 32'(resp_data_ok_o), 32'd0);
            if (c == kb) bump_err(br);
        end
        @(negedge clk);
        idle_slave();
        #1;
        chk("wack_ok", 32'(resp_data_ok_o), 32'd1);
        chk("wack_wvalid", 32'(wvalid), 32'd0);
        chk("wack_ready", 32'(resp_ready_o), 32'd0);
        @(negedge clk);
        req_data_ok_i = 0; req_data_last_i = 0;
        #1;
        chk("w_done_ready", 32'(resp_ready_o), 32'd1);
        chk("w_done_ok", 32'(resp_data_ok_o), 32'd0);
        chk_err_cnt();
    endtask

    initial begin
        logic [31:0] d [4];
        logic [3:0]  s [4];
        for (int i = 0; i < 64; i++) begin
            logic [31:0] v = $urandom;
            slave_mem[i] = v;
            ref_mem[i]   = v;
        end
        rst_n = 0;
        req_valid_i = 0; req_write_i = 0; req_burst_i = 0; req_cached_i = 0;
        req_addr_i = 0; req_w_data_i = 0; req_data_strobe_i = 0;
        req_data_ok_i = 0; req_data_last_i = 0;
        idle_slave();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_resp_ready", 32'(resp_ready_o), 32'd1);
        chk("rst_arvalid0", 32'(arvalid), 32'd0);
        chk("rst_awvalid0", 32'(awvalid), 32'd0);
        chk("rst_wvalid0", 32'(wvalid), 32'd0);
        chk("rst_rready0", 32'(rready), 32'd0);
        chk("rst_bready0", 32'(bready), 32'd0);
        chk("rst_ok0", 32'(resp_data_ok_o), 32'd0);
        chk("rst_err0", 32'(err_cnt_o), 32'd0);
        rst_n = 1;

        slave_mem[idx(32'h1FD0_0010)] = 32'hDEADBEEF;
        ref_mem[idx(32'h1FD0_0010)]   = 32'hDEADBEEF;
        do_read(32'h1FD0_0010, 1'b0, 1'b0, -1);
        do_read(32'h0000_1000, 1'b1, 1'b1, -1);

        for (int i = 0; i < 4; i++) begin d[i] = $urandom; s[i] = 4'b1000; end
        do_write(32'h0000_2003, 1'b0, 1'b0, d, s);
        for (int i = 0; i < 4; i++) begin d[i] = $urandom; s[i] = 4'hF; end
        do_write(32'h0000_1040, 1'b1, 1'b1, d, s);
        do_read(32'h0000_1040, 1'b1, 1'b1, -1);

        do_read(32'h0000_1080, 1'b1, 1'b1, 2);
        do_read(32'h0000_1080, 1'b1, 1'b1, -1);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a = {24'h0000_30, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            logic bu = 1'($urandom_range(0, 1));
            logic ca = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) begin d[i] = $urandom; s[i] = 4'($urandom); end
                do_write(a, bu, ca, d, s);
            end else begin
                do_read(a, bu, ca, -1);
            end
        end

        g_rresp = 2;
        do_read(32'h0000_0100, 1'b0, 1'b0, -1);
        g_rresp = -1;
        g_bresp = 3;
        for (int i = 0; i < 4; i++) begin d[i] = $urandom; s[i] = 4'hF; end
        do_write(32'h0000_0104, 1'b0, 1'b0, d, s);
        g_bresp = -1;
        do_read(32'h0000_0104, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
